// File: rtl/serial_mult_io.sv
// serial_mult_io: byte-serial operand loader feeding a 16x16 shift-add multiplier.
// Four ctrl strobes load A (low, high) then B (low, high); 16 MUL clocks later
// data_out presents {done, A*B} and holds it until the next operation starts.
module serial_mult_io (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_in,
   input  logic        ctrl,
   output logic [32:0] data_out
);

   typedef enum logic {LOAD, MUL} state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [31:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ctrl_q;
   logic [32:0] dout_q, dout_d;
   logic        strobe;
   logic [31:0] partial;

   // a held ctrl level yields one strobe, on its rising edge only
   assign strobe   = ctrl & ~ctrl_q;
   assign data_out = dout_q;

   // next-state: byte capture while loading, one multiplier bit per clock while multiplying
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      partial = 32'h0;
      case (state_q)
         LOAD: begin
            if (strobe) begin
               case (idx_q)
                  2'd0: begin
                     a_d[7:0]   = data_in;
                     dout_d[32] = 1'b0;   // new operation: drop done, keep old product visible
                  end
                  2'd1: a_d[15:8] = data_in;
                  2'd2: b_d[7:0]  = data_in;
                  default: begin
                     b_d[15:8] = data_in;
                     acc_d     = 32'h0;
                     cnt_d     = 4'd0;
                     state_d   = MUL;
                  end
               endcase
               idx_d = idx_q + 2'd1;     // wraps 3 -> 0
            end
         end
         default: begin
            // A stays put; the shift amount tracks which multiplier bit is at b_q[0]
            if (b_q[0])
               partial = {16'h0, a_q} << cnt_q;
            acc_d = acc_q + partial;
            b_d   = {1'b0, b_q[15:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               dout_d  = {1'b1, acc_d};
               state_d = LOAD;
            end
         end
      endcase
   end

   // state registers with synchronous reset that aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         idx_q   <= 2'd0;
         a_q     <= 16'h0;
         b_q     <= 16'h0;
         acc_q   <= 32'h0;
         cnt_q   <= 4'd0;
         ctrl_q  <= 1'b0;
         dout_q  <= 33'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl;
         dout_q  <= dout_d;
      end
   end

endmodule

// File: tb/tb_serial_mult_io.sv
// Directed + randomized bench for serial_mult_io; expected products are plain A*B.
module tb_serial_mult_io;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        ctrl;
   logic [32:0] data_out;

   int total = 0;
   int bad   = 0;
   logic [31:0] prev_prod;   // what data_out[31:0] should hold between operations

   serial_mult_io dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .ctrl     (ctrl),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // raise ctrl for 'hold' clocks; returns on the negedge after the clock following release
   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge clk);
      data_in = b;
      ctrl    = 1'b1;
      repeat (hold) @(negedge clk);
      ctrl = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      ctrl = 1'b0;
      rst  = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_out", data_out, 33'h0);
      rst       = 1'b0;
      prev_prod = 32'h0;
   endtask

   // one full operation; noise toggles ctrl/data_in during the multiply
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int h0, input int h, input bit noise);
      logic [31:0] exp_prod;
      exp_prod = 32'(a) * 32'(b);
      send_byte(a[7:0], h0);
      chk({tag, "_start"}, data_out, {1'b0, prev_prod});
      send_byte(a[15:8], 1);
      send_byte(b[7:0], 1);
      send_byte(b[15:8], h);
      // byte3 captured h+1 clocks ago; result lands on the 16th clock after capture
      repeat (15 - h) @(negedge clk) begin
         if (noise) begin
            ctrl    = ~ctrl;
            data_in = 8'($urandom);
         end
      end
      ctrl = 1'b0;
      chk({tag, "_early"}, data_out, {1'b0, prev_prod});
      @(negedge clk);
      chk({tag, "_result"}, data_out, {1'b1, exp_prod});
      prev_prod = exp_prod;
      repeat (3) @(negedge clk);
      chk({tag, "_hold"}, data_out, {1'b1, exp_prod});
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst       = 1'b1;
      ctrl      = 1'b0;
      data_in   = 8'h0;
      prev_prod = 32'h0;
      do_reset();

      run_op("basic", 16'h2B0A, 16'h02AA, 2, 1, 1'b0);
      run_op("maxmax", 16'hFFFF, 16'hFFFF, 1, 2, 1'b0);
      run_op("a_zero", 16'h0000, 16'h1234, 1, 1, 1'b0);
      run_op("b_zero", 16'hBEEF, 16'h0000, 1, 1, 1'b0);
      run_op("long_hold", 16'h1357, 16'h9BDF, 5, 1, 1'b0);
      run_op("mul_noise", 16'hA5A5, 16'h5A5A, 1, 1, 1'b1);

      // abort after two bytes, then a clean operation
      send_byte(8'h77, 1);
      send_byte(8'h88, 1);
      do_reset();
      run_op("after_rst_load", 16'h0102, 16'h0304, 1, 1, 1'b0);

      // abort in the middle of the multiply
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      send_byte(8'h33, 1);
      send_byte(8'h44, 1);
      repeat (5) @(negedge clk);
      do_reset();
      run_op("after_rst_mul", 16'hFEDC, 16'h0FF1, 1, 1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op("rand", ra, rb, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
